// File: rtl/enc_stream_arbiter.sv
// Two-channel character encryptor: round-robin arbitration onto one shared
// 7-bit datapath, per-channel rolling keys, one registered output slot with
// valid/ready backpressure. A zero character ends a message and restores the
// channel's base key.
module enc_stream_arbiter #(
  parameter int ROT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [6:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [6:0]       req1_data,
  output logic             req1_ready,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [6:0]       cfg_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic             out_src,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx
);

  // slotState | meaning
  // EMPTY     | nothing waiting for the sink
  // FULL      | out_* holds an encrypted character until out_ready

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slotState_e;

  slotState_e       slotState, slotNext;
  logic             rrPtr;
  logic [6:0]       baseKey [0:1];
  logic [6:0]       curKey  [0:1];
  logic [CNT_W-1:0] idx     [0:1];

  logic             slotFree, grantAny, winner, isLast;
  logic [1:0]       grantVec;
  logic [6:0]       selData;

  function automatic logic [6:0] encrypt(input logic [6:0] m, input logic [6:0] k);
    logic [6:0] i;
    i = {~m[6], m[1], ~m[4], m[5], ~m[2], m[3], ~m[0]};
    return (m == 7'd0) ? 7'd0 : (i ^ k);
  endfunction

  // Doubling the key makes the wrapped-around bits fall out of a plain shift.
  function automatic logic [6:0] rotl7(input logic [6:0] k);
    logic [13:0] twice;
    twice = {k, k} << ROT;
    return twice[13:7];
  endfunction

  // Arbitration: the pointer only matters when both channels request.
  always_comb begin
    slotFree   = (slotState == EMPTY) || out_ready;
    grantAny   = en && slotFree && (req0_valid || req1_valid);
    winner     = (req0_valid && req1_valid) ? rrPtr : !req0_valid;
    req0_ready = grantAny && !winner;
    req1_ready = grantAny && winner;
    grantVec   = {req1_ready, req0_ready};
    selData    = winner ? req1_data : req0_data;
    isLast     = (selData == 7'd0);
  end

  // Output slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slotState <= EMPTY;
    else        slotState <= slotNext;
  end

  // A same-cycle grant refills the slot as it drains, so it never goes EMPTY.
  always_comb begin
    slotNext = slotState;
    if (grantAny)       slotNext = FULL;
    else if (out_ready) slotNext = EMPTY;
  end

  assign out_valid = (slotState == FULL);

  // Output fields load only on a grant, so they hold while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= 1'b0;
      out_last <= 1'b0;
      out_idx  <= '0;
    end else if (grantAny) begin
      out_data <= encrypt(selData, curKey[winner]);
      out_src  <= winner;
      out_last <= isLast;
      out_idx  <= idx[winner];
    end
  end

  // Round-robin pointer prefers the channel that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rrPtr <= 1'b0;
    else if (grantAny) rrPtr <= !winner;
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : gChan
    // Per-channel key schedule; a config write overrides a same-cycle grant update.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        baseKey[g] <= '0;
        curKey[g]  <= '0;
        idx[g]     <= '0;
      end else if (cfg_we && (cfg_sel == 1'(g))) begin
        baseKey[g] <= cfg_key;
        curKey[g]  <= cfg_key;
        idx[g]     <= '0;
      end else if (grantVec[g]) begin
        if (isLast) begin
          curKey[g] <= baseKey[g];
          idx[g]    <= '0;
        end else begin
          curKey[g] <= rotl7(curKey[g]);
          idx[g]    <= (idx[g] == {CNT_W{1'b1}}) ? idx[g] : idx[g] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_stream_arbiter.sv
// Bench for enc_stream_arbiter: a behavioural model predicts grants and pushes
// expected output records to a queue; records are popped when the sink
// accepts. A vector table covers the basic streams, hand sequences cover
// backpressure, config collision, enable gating, async reset and saturation.
module tb_enc_stream_arbiter;
  localparam int CNT_W = 8;
  localparam int ROT   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready;
  logic cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [6:0] cfg_key = '0;
  logic out_valid, out_ready = 1'b0;
  logic [6:0] out_data;
  logic out_src, out_last;
  logic [CNT_W-1:0] out_idx;

  int checks = 0;
  int errors = 0;

  enc_stream_arbiter #(.ROT(ROT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_key(cfg_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]       data;
    logic             src;
    logic             last;
    logic [CNT_W-1:0] idx;
  } outRec_t;

  typedef struct {
    logic       rst;
    logic       en, v0;
    logic [6:0] d0;
    logic       v1;
    logic [6:0] d1;
    logic       rdy, we, sel;
    logic [6:0] key;
    logic       r0, r1, ov, chkD;
    logic [6:0] od;
  } vec_t;

  outRec_t          sbQ[$];
  logic [6:0]       mBase [2];
  logic [6:0]       mCur  [2];
  logic [CNT_W-1:0] mIdx  [2];
  logic             mPtr;
  vec_t             vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] modelEnc(input logic [6:0] m, input logic [6:0] k);
    logic [6:0] i;
    if (m == 7'd0) return 7'd0;
    i[0] = ~m[0]; i[2] = ~m[2]; i[4] = ~m[4]; i[6] = ~m[6];
    i[1] = m[3];  i[3] = m[5];  i[5] = m[1];
    return i ^ k;
  endfunction

  function automatic logic [6:0] modelRot(input logic [6:0] k);
    logic [6:0] r;
    r = k;
    for (int n = 0; n < ROT; n++) r = {r[5:0], r[6]};
    return r;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      mBase[c] = '0; mCur[c] = '0; mIdx[c] = '0;
    end
    mPtr = 1'b0;
    sbQ.delete();
  endtask

  task automatic drive(input logic e, input logic v0, input logic [6:0] d0,
                       input logic v1, input logic [6:0] d1, input logic rdy,
                       input logic we, input logic sel, input logic [6:0] key);
    en = e; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    out_ready = rdy; cfg_we = we; cfg_sel = sel; cfg_key = key;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b1, 1'b0, 7'h00, 1'b0, 7'h00, rdy, 1'b0, 1'b0, 7'h00);
  endtask

  // One clock: scoreboard check and model step on the falling edge, then
  // return just after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    logic hadValid, grant, w, e0, e1;
    logic [6:0] m;
    outRec_t r;
    @(negedge clk);
    hadValid = (sbQ.size() != 0);
    chk("out_valid", out_valid, hadValid);
    if (hadValid) begin
      chk("out_data", out_data, sbQ[0].data);
      chk("out_src",  out_src,  sbQ[0].src);
      chk("out_last", out_last, sbQ[0].last);
      chk("out_idx",  out_idx,  sbQ[0].idx);
      if (out_ready) void'(sbQ.pop_front());
    end
    grant = en && (!hadValid || out_ready) && (req0_valid || req1_valid);
    w  = (req0_valid && req1_valid) ? mPtr : (req0_valid ? 1'b0 : 1'b1);
    e0 = grant && !w;
    e1 = grant && w;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (grant) begin
      m = w ? req1_data : req0_data;
      r.data = modelEnc(m, mCur[w]);
      r.src  = w;
      r.last = (m == 7'd0);
      r.idx  = mIdx[w];
      sbQ.push_back(r);
      if (!(cfg_we && cfg_sel == w)) begin
        if (m == 7'd0) begin
          mCur[w] = mBase[w]; mIdx[w] = '0;
        end else begin
          mCur[w] = modelRot(mCur[w]);
          if (mIdx[w] != {CNT_W{1'b1}}) mIdx[w] = mIdx[w] + 1'b1;
        end
      end
      mPtr = !w;
    end
    if (cfg_we) begin
      mBase[cfg_sel] = cfg_key; mCur[cfg_sel] = cfg_key; mIdx[cfg_sel] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    idle(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 7'h00);
    chk("rst out_src", out_src, 1'b0);
    chk("rst out_last", out_last, 1'b0);
    chk("rst out_idx", out_idx, 0);
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  function automatic vec_t mk(input logic rst, input logic v0, input logic [6:0] d0,
                              input logic v1, input logic [6:0] d1, input logic we,
                              input logic [6:0] key, input logic r0, input logic r1,
                              input logic ov, input logic chkD, input logic [6:0] od);
    vec_t v;
    v.rst = rst; v.en = 1'b1; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.rdy = 1'b1; v.we = we; v.sel = 1'b0; v.key = key;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.chkD = chkD; v.od = od;
    return v;
  endfunction

  initial begin
    modelReset();
    //                rst v0   d0     v1   d1     we   key    r0 r1 ov chkD od
    vecs.push_back(mk(1, 0, 7'h00, 0, 7'h00, 1, 7'h2A, 0, 0, 0, 0, 7'h00));
    vecs.push_back(mk(0, 1, 7'h41, 0, 7'h00, 0, 7'h00, 1, 0, 0, 0, 7'h00));
    vecs.push_back(mk(0, 1, 7'h41, 0, 7'h00, 0, 7'h00, 1, 0, 1, 1, 7'h3E));
    vecs.push_back(mk(0, 1, 7'h00, 0, 7'h00, 0, 7'h00, 1, 0, 1, 1, 7'h40));
    vecs.push_back(mk(0, 1, 7'h41, 0, 7'h00, 0, 7'h00, 1, 0, 1, 1, 7'h00));
    vecs.push_back(mk(0, 0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0, 1, 1, 7'h3E));
    vecs.push_back(mk(0, 0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 7'h00));
    vecs.push_back(mk(1, 1, 7'h41, 1, 7'h41, 0, 7'h00, 1, 0, 0, 0, 7'h00));
    vecs.push_back(mk(0, 1, 7'h41, 1, 7'h41, 0, 7'h00, 0, 1, 1, 1, 7'h14));
    vecs.push_back(mk(0, 1, 7'h41, 1, 7'h41, 0, 7'h00, 1, 0, 1, 1, 7'h14));
    vecs.push_back(mk(0, 1, 7'h41, 1, 7'h41, 0, 7'h00, 0, 1, 1, 1, 7'h14));
    vecs.push_back(mk(0, 0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0, 1, 1, 7'h14));
    vecs.push_back(mk(0, 0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 7'h00));

    foreach (vecs[n]) begin
      if (vecs[n].rst) applyReset();
      drive(vecs[n].en, vecs[n].v0, vecs[n].d0, vecs[n].v1, vecs[n].d1,
            vecs[n].rdy, vecs[n].we, vecs[n].sel, vecs[n].key);
      #1;
      chk("vec req0_ready", req0_ready, vecs[n].r0);
      chk("vec req1_ready", req1_ready, vecs[n].r1);
      chk("vec out_valid", out_valid, vecs[n].ov);
      if (vecs[n].chkD) chk("vec out_data", out_data, vecs[n].od);
      cycle();
    end

    // Backpressure: slot stays full, no grants, fields stable, then full rate.
    applyReset();
    drive(1, 1, 7'h42, 1, 7'h43, 0, 0, 0, 7'h00);
    cycle();
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("stall req0_ready", req0_ready, 1'b0);
      chk("stall req1_ready", req1_ready, 1'b0);
      chk("stall out_data", out_data, 7'h35);
      chk("stall out_src", out_src, 1'b0);
      cycle();
    end
    drive(1, 1, 7'h42, 1, 7'h43, 1, 0, 0, 7'h00);
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("resume out_valid", out_valid, 1'b1);
      cycle();
    end
    idle(1'b1);
    cycle();
    cycle();

    // Config write colliding with a grant on the same channel.
    applyReset();
    drive(1, 0, 7'h00, 0, 7'h00, 1, 1, 0, 7'h2A);
    cycle();
    drive(1, 1, 7'h41, 0, 7'h00, 1, 1, 0, 7'h7F);
    #1;
    chk("cfg grant req0_ready", req0_ready, 1'b1);
    cycle();
    drive(1, 1, 7'h41, 0, 7'h00, 1, 0, 0, 7'h00);
    #1;
    chk("cfg old key out_data", out_data, 7'h3E);
    cycle();
    idle(1'b1);
    #1;
    chk("cfg new key out_data", out_data, 7'h6B);
    chk("cfg new key out_idx", out_idx, 0);
    cycle();
    cycle();

    // Enable low: drain only, then resume at the preferred channel.
    applyReset();
    drive(1, 1, 7'h41, 1, 7'h41, 0, 0, 0, 7'h00);
    cycle();
    drive(0, 1, 7'h41, 1, 7'h41, 1, 0, 0, 7'h00);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("en0 req0_ready", req0_ready, 1'b0);
      chk("en0 req1_ready", req1_ready, 1'b0);
      if (n > 0) chk("en0 drained", out_valid, 1'b0);
      cycle();
    end
    drive(1, 1, 7'h41, 1, 7'h41, 1, 0, 0, 7'h00);
    #1;
    chk("en1 req1_ready", req1_ready, 1'b1);
    chk("en1 req0_ready", req0_ready, 1'b0);
    cycle();
    idle(1'b1);
    cycle();
    cycle();

    // Asynchronous reset while a character is pending.
    applyReset();
    drive(1, 0, 7'h00, 0, 7'h00, 1, 1, 0, 7'h2A);
    cycle();
    drive(1, 1, 7'h41, 0, 7'h00, 0, 0, 0, 7'h00);
    cycle();
    idle(1'b0);
    chk("pre-reset out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", out_valid, 1'b0);
    chk("async out_data", out_data, 7'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    drive(1, 1, 7'h41, 1, 7'h41, 1, 0, 0, 7'h00);
    #1;
    chk("post-reset req0_ready", req0_ready, 1'b1);
    cycle();
    idle(1'b1);
    #1;
    chk("post-reset key out_data", out_data, 7'h14);
    cycle();
    cycle();

    // Index saturation on a long message.
    applyReset();
    for (int n = 0; n < 260; n++) begin
      drive(1, 0, 7'h00, 1, 7'($urandom_range(1, 127)), 1, 0, 0, 7'h00);
      cycle();
    end
    idle(1'b1);
    #1;
    chk("saturated out_idx", out_idx, 255);
    cycle();
    cycle();

    // Randomised traffic against the model.
    applyReset();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(1, 127)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(1, 127)),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)),
            7'($urandom_range(0, 127)));
      cycle();
    end
    idle(1'b1);
    for (int n = 0; n < 3; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enc_stream_arbiter.md
Name: enc_stream_arbiter

Overview:
- Shares one 7-bit encryption datapath between two character requesters (channel 0, channel 1).
- Holds a per-channel rolling private key and round-robin arbitrates requests.
- Encrypts one character per grant into a single registered output slot with valid/ready backpressure.
- Sits between the ASCII message sources and the encrypted-message sink; a zero character terminates a message.

Parameters:
ROT, 1, left-rotate amount applied to a channel key after each non-zero character (0..6; 0 gives a static key)
CNT_W, 8, width of the per-channel character-index counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low blocks new grants, output still drains
req0_valid  in  1  channel 0 character valid
req0_data  in  7  channel 0 ASCII character
req0_ready  out  1  channel 0 accepted this cycle (grant)
req1_valid  in  1  channel 1 character valid
req1_data  in  7  channel 1 ASCII character
req1_ready  out  1  channel 1 accepted this cycle (grant)
cfg_we  in  1  key write strobe
cfg_sel  in  1  channel addressed by key write
cfg_key  in  7  new base key
out_valid  out  1  output slot holds an encrypted character
out_ready  in  1  sink accepts output
out_data  out  7  encrypted character
out_src  out  1  originating channel
out_last  out  1  character was a terminator (input 0)
out_idx  out  CNT_W  0-based position of character within its message

Behaviour:
- Encryption E(m,k), combinational:
  - m==0 -> 0, regardless of k.
  - Otherwise build i: i0=~m0, i2=~m2, i4=~m4, i6=~m6, i1=m3, i3=m5, i5=m1.
  - E = i ^ k.
- Reset (async, rst_n low):
  - out_valid=0; out_data, out_src, out_last, out_idx all 0; req*_ready=0.
  - Base and current keys 0; index counters 0; round-robin pointer favours channel 0.
- Output slot, states EMPTY/FULL:
  - slot_free = !out_valid || out_ready.
  - A grant occurs only when en && slot_free && at least one req valid.
  - Granted character loads the slot on the next edge (1-cycle latency, one char/cycle sustained with out_ready=1).
  - out_valid falls only when out_ready is high and there is no same-cycle grant.
  - Output fields hold stable while out_valid && !out_ready.
- Arbitration:
  - Round-robin; pointer names the preferred channel.
  - Both valid -> preferred channel wins. Pointer moves to the other channel after every grant.
  - Single valid -> that channel wins.
  - reqN_ready is combinational and asserted only for the winning channel.
- Key schedule, per channel:
  - Granted non-zero char uses the current key; then current key <= rotl7(current, ROT) and idx <= idx+1, saturating at 2^CNT_W-1.
  - Granted zero char: out_last=1, out_data=0, out_idx = current idx; then current key <= base key, idx <= 0.
- Config:
  - cfg_we writes base key and current key of channel cfg_sel, and clears its idx.
  - Accepted every cycle, including while the slot is FULL.
  - If the same channel is granted in the same cycle, the grant encrypts with the old key; the config write takes priority over the rotate/idx update.
- en low: no grants, keys frozen; slot drains normally.
- Reset mid-operation clears any pending output; it is not delivered.

Test Plan:
1. Reset, key0=0x2A, single channel-0 stream 'A','A',0x00 with out_ready=1 -> out_data 0x3E (idx0), 0x40 (idx1), then 0x00 with out_last=1, idx2; next 'A' encrypts to 0x3E again (key restored).
2. Both channels continuously valid, keys 0x00 -> grants alternate 0,1,0,1 starting with channel 0; 'A' from each yields 0x14 first; out_src alternates.
3. Backpressure: out_ready=0 for 5 cycles with slot FULL -> req*_ready stay 0, out_data/out_src stable; out_ready=1 then resumes one char per cycle.
4. cfg_we to channel 0 with key 0x7F in the same cycle channel 0 is granted 'A' under key 0x2A -> output 0x3E; next 'A' outputs 0x6B (key 0x7F, idx0).
5. en=0 with requests pending -> no grants, in-flight char still delivered; en=1 resumes at the preferred channel.
6. Assert rst_n low asynchronously while out_valid=1 -> out_valid drops immediately, keys and idx return to 0, channel 0 is preferred first after release.
